// File: rtl/inst_pkg.sv
// ============================================================================
//  Module      : inst_pkg
//  Description : Shared constants for the instruction prefetch stage and the
//                controller: ARM condition codes, fetch FSM states, NZCV bits.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package inst_pkg;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam int NZCV_N = 3;
    localparam int NZCV_Z = 2;
    localparam int NZCV_C = 1;
    localparam int NZCV_V = 0;

endpackage

`default_nettype wire

// File: rtl/cond_check.sv
// ============================================================================
//  Module      : cond_check
//  Description : Combinational ARM condition-code evaluator against NZCV.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module cond_check
    import inst_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_nzcv,
    output logic       o_pass
);

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;

    assign w_n = i_nzcv[NZCV_N];
    assign w_z = i_nzcv[NZCV_Z];
    assign w_c = i_nzcv[NZCV_C];
    assign w_v = i_nzcv[NZCV_V];

    always_comb begin
        o_pass = 1'b0;
        case (i_cond)
            COND_EQ: o_pass = w_z;
            COND_NE: o_pass = ~w_z;
            COND_CS: o_pass = w_c;
            COND_CC: o_pass = ~w_c;
            COND_MI: o_pass = w_n;
            COND_PL: o_pass = ~w_n;
            COND_VS: o_pass = w_v;
            COND_VC: o_pass = ~w_v;
            COND_HI: o_pass = w_c & ~w_z;
            COND_LS: o_pass = ~w_c | w_z;
            COND_GE: o_pass = (w_n == w_v);
            COND_LT: o_pass = (w_n != w_v);
            COND_GT: o_pass = ~w_z & (w_n == w_v);
            COND_LE: o_pass = w_z | (w_n != w_v);
            COND_AL: o_pass = 1'b1;
            // The reserved encoding never executes.
            COND_NV: o_pass = 1'b0;
            default: o_pass = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/inst_prefetch.sv
// ============================================================================
//  Module      : inst_prefetch
//  Description : Instruction prefetch from a 1-cycle ROM into a small FIFO,
//                with PC redirect/flush and head condition-pass evaluation.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module inst_prefetch
    import inst_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 2
)(
    input  logic              clk,
    input  logic              Rst,
    output logic [ADDR_W-1:0] Mem_addr,
    output logic              Mem_req,
    input  logic [31:0]       Mem_data,
    input  logic              Take_IR,
    input  logic              Redirect,
    input  logic [ADDR_W-1:0] Redirect_addr,
    input  logic [3:0]        NZCV,
    output logic              IR_valid,
    output logic [31:0]       IR,
    output logic [ADDR_W-1:0] IR_addr,
    output logic              flag
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int RES_W = CNT_W + 1;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic              r_inflight;
    logic [ADDR_W-1:0] r_infl_addr;
    logic [31:0]       r_data_mem [DEPTH];
    logic [ADDR_W-1:0] r_addr_mem [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;

    logic              w_pop;
    logic              w_push;
    logic              w_req;
    logic              w_pass;
    logic [RES_W-1:0]  w_reserved;
    logic [31:0]       w_head_data;

    assign IR_valid    = (r_count != '0);
    assign w_pop       = Take_IR & IR_valid;
    // A redirect kills the word returning this cycle.
    assign w_push      = r_inflight & ~Redirect;
    // Slots held plus slots promised to the in-flight read, after this pop.
    assign w_reserved  = RES_W'(r_count) + RES_W'(r_inflight) - RES_W'(w_pop);
    assign w_req       = (r_state == ST_FETCH) & ~Redirect & (w_reserved < RES_W'(DEPTH));

    assign Mem_req     = w_req;
    assign Mem_addr    = r_pc;

    assign w_head_data = r_data_mem[r_head];
    assign IR          = IR_valid ? w_head_data : '0;
    assign IR_addr     = IR_valid ? r_addr_mem[r_head] : '0;
    assign flag        = IR_valid & w_pass;

    cond_check u_cond_check (
        .i_cond (w_head_data[31:28]),
        .i_nzcv (NZCV),
        .o_pass (w_pass)
    );

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            r_state     <= ST_IDLE;
            r_pc        <= '0;
            r_inflight  <= 1'b0;
            r_infl_addr <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
        end else begin
            r_inflight <= w_req;
            if (w_req) begin
                r_infl_addr <= r_pc;
            end

            if (Redirect) begin
                r_pc    <= Redirect_addr;
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_req) begin
                    r_pc <= r_pc + ADDR_W'(1);
                end
                if (w_push) begin
                    r_tail <= r_tail + PTR_W'(1);
                end
                if (w_pop) begin
                    r_head <= r_head + PTR_W'(1);
                end
                r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            end

            case (r_state)
                ST_IDLE:  r_state <= ST_FETCH;
                ST_FETCH: if (Redirect)  r_state <= ST_FLUSH;
                ST_FLUSH: if (!Redirect) r_state <= ST_FETCH;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data_mem[r_tail] <= Mem_data;
            r_addr_mem[r_tail] <= r_infl_addr;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_inst_prefetch.sv
// ============================================================================
//  Module      : tb_inst_prefetch
//  Description : Scoreboard bench for inst_prefetch with a ROM model and a
//                program-order reference of expected instruction addresses.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_inst_prefetch;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 2;

    logic              clk = 1'b0;
    logic              Rst;
    logic [ADDR_W-1:0] Mem_addr;
    logic              Mem_req;
    logic [31:0]       Mem_data;
    logic              Take_IR;
    logic              Redirect;
    logic [ADDR_W-1:0] Redirect_addr;
    logic [3:0]        NZCV;
    logic              IR_valid;
    logic [31:0]       IR;
    logic [ADDR_W-1:0] IR_addr;
    logic              flag;

    inst_prefetch #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .Rst           (Rst),
        .Mem_addr      (Mem_addr),
        .Mem_req       (Mem_req),
        .Mem_data      (Mem_data),
        .Take_IR       (Take_IR),
        .Redirect      (Redirect),
        .Redirect_addr (Redirect_addr),
        .NZCV          (NZCV),
        .IR_valid      (IR_valid),
        .IR            (IR),
        .IR_addr       (IR_addr),
        .flag          (flag)
    );

    always #5 clk = ~clk;

    logic [31:0]       rom [64];
    logic [ADDR_W-1:0] exp_q [$];
    logic [ADDR_W-1:0] next_addr;
    int                checks   = 0;
    int                failures = 0;
    int                pops     = 0;

    function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c)
            4'h0:    return z;
            4'h1:    return !z;
            4'h2:    return cf;
            4'h3:    return !cf;
            4'h4:    return n;
            4'h5:    return !n;
            4'h6:    return v;
            4'h7:    return !v;
            4'h8:    return cf && !z;
            4'h9:    return !cf || z;
            4'hA:    return n == v;
            4'hB:    return n != v;
            4'hC:    return !z && (n == v);
            4'hD:    return z || (n != v);
            4'hE:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Expected program order: sequential from the last reset/redirect target.
    task automatic top_up();
        while (exp_q.size() < 8) begin
            exp_q.push_back(next_addr);
            next_addr = next_addr + ADDR_W'(1);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        top_up();
    endtask

    // Synchronous ROM: answers one cycle after a request, garbage otherwise.
    logic              rom_req;
    logic [ADDR_W-1:0] rom_a;
    always begin
        @(negedge clk);
        rom_req = Mem_req;
        rom_a   = Mem_addr;
        @(posedge clk);
        #1;
        Mem_data = rom_req ? rom[rom_a] : $urandom;
    end

    // Monitor: compares the head against the scoreboard before each edge.
    always @(negedge clk) begin
        logic [31:0] exp_word;
        if (!Rst) begin
            if (!IR_valid) begin
                chk("empty_IR", IR, 0);
                chk("empty_IR_addr", IR_addr, 0);
                chk("empty_flag", flag, 0);
            end else if (!Redirect) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL scoreboard_empty actual=valid required=none t=%0t", $time);
                end else begin
                    exp_word = rom[exp_q[0]];
                    chk("head_addr", IR_addr, exp_q[0]);
                    chk("head_IR", IR, exp_word);
                    chk("head_flag", flag, cond_ref(exp_word[31:28], NZCV));
                    if (Take_IR) begin
                        void'(exp_q.pop_front());
                        pops++;
                    end
                end
            end
        end
    end

    task automatic do_redirect(input logic [ADDR_W-1:0] a, input logic take);
        Redirect      = 1'b1;
        Redirect_addr = a;
        Take_IR       = take;
        exp_q.delete();
        next_addr = a;
        top_up();
        step();
        Redirect = 1'b0;
        NZCV     = 4'($urandom);
        chk("rd_valid_R", IR_valid, 0);
        chk("rd_req_R", Mem_req, 0);
        chk("rd_flag_invalid", flag, 0);
        step();
        chk("rd_req_R1", Mem_req, 1);
        chk("rd_addr_R1", Mem_addr, a);
        step();
        chk("rd_valid_R2", IR_valid, 0);
        step();
        chk("rd_valid_R3", IR_valid, 1);
        chk("rd_head_R3", IR_addr, a);
    endtask

    initial begin
        Rst           = 1'b1;
        Take_IR       = 1'b0;
        Redirect      = 1'b0;
        Redirect_addr = '0;
        NZCV          = 4'h0;
        Mem_data      = '0;
        next_addr     = '0;
        for (int i = 0; i < 64; i++) rom[i] = $urandom;
        for (int i = 0; i < 4; i++)  rom[i] = 32'hE081_0002 + 32'(i);
        for (int k = 0; k < 16; k++) rom[40+k] = {4'(k), rom[40+k][27:0]};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_Mem_req", Mem_req, 0);
        chk("rst_Mem_addr", Mem_addr, 0);
        chk("rst_IR_valid", IR_valid, 0);
        chk("rst_IR", IR, 0);
        chk("rst_IR_addr", IR_addr, 0);
        chk("rst_flag", flag, 0);

        // Startup latency and back-pressure with no consumer.
        Rst = 1'b0;
        top_up();
        step();
        chk("E0_req", Mem_req, 1);
        chk("E0_addr", Mem_addr, 0);
        step();
        chk("E1_req", Mem_req, 1);
        chk("E1_addr", Mem_addr, 1);
        chk("E1_valid", IR_valid, 0);
        step();
        chk("E2_valid", IR_valid, 1);
        chk("E2_head", IR_addr, 0);
        chk("E2_req", Mem_req, 0);
        repeat (4) begin
            step();
            chk("full_noreq", Mem_req, 0);
            chk("full_head", IR_addr, 0);
        end

        // Streaming with no bubbles.
        Take_IR = 1'b1;
        repeat (8) begin
            step();
            chk("no_bubble", IR_valid, 1);
        end

        // PC wrap.
        do_redirect(6'd62, 1'b1);
        chk("wrap_addr", Mem_addr, 0);
        repeat (6) step();

        // Redirect while full, together with Take_IR.
        Take_IR = 1'b0;
        repeat (4) step();
        do_redirect(6'd20, 1'b1);
        repeat (5) step();
        // Redirect with a request in flight.
        do_redirect(6'd33, 1'b1);
        repeat (4) step();

        // Condition sweep on the head instruction.
        for (int k = 0; k < 16; k++) begin
            do_redirect(6'(40 + k), 1'b0);
            for (int n = 0; n < 16; n++) begin
                step();
                NZCV = 4'(n);
                #1;
                chk("cond_sweep", flag, cond_ref(4'(k), 4'(n)));
            end
        end

        // Randomised traffic with redirects.
        pops = 0;
        for (int i = 0; i < 1500; i++) begin
            step();
            NZCV    = 4'($urandom);
            Take_IR = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 24) == 0) begin
                Redirect      = 1'b1;
                Redirect_addr = 6'($urandom);
                exp_q.delete();
                next_addr = Redirect_addr;
                top_up();
            end else begin
                Redirect = 1'b0;
            end
        end
        Redirect = 1'b0;
        chk("throughput", (pops > 600), 1);

        // Asynchronous reset mid-stream.
        Take_IR = 1'b1;
        repeat (5) step();
        @(posedge clk);
        #2;
        Rst = 1'b1;
        exp_q.delete();
        #1;
        chk("arst_Mem_req", Mem_req, 0);
        chk("arst_Mem_addr", Mem_addr, 0);
        chk("arst_IR_valid", IR_valid, 0);
        chk("arst_IR", IR, 0);
        chk("arst_IR_addr", IR_addr, 0);
        chk("arst_flag", flag, 0);
        @(posedge clk);
        #1;
        Rst       = 1'b0;
        next_addr = '0;
        top_up();
        step();
        step();
        step();
        chk("arst_restart_valid", IR_valid, 1);
        chk("arst_restart_head", IR_addr, 0);
        repeat (20) step();
        Take_IR = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
